// File: rtl/framebuffer_swap_controller.sv
// ---------------------------------------------------------------------------
// framebuffer_swap_controller
//
// Purpose:
//   Sequences double-buffered rendering into a framebuffer RAM that holds two
//   FB_SIZE-word buffers. The renderer draws into the back buffer while
//   scan-out reads the front buffer. The buffers swap only at a scan-out
//   frame start, and only after the renderer has reported a finished frame.
//
// Optional feature (compile-time macro CLEAR_ON_FLIP_EN):
//   When defined, the freshly swapped back buffer is filled with CLEAR_VALUE,
//   one word per clock, before it is handed back to the renderer. When not
//   defined, the clear state and its counter are not built and the clear
//   write port is tied to zero.
//
// Ports:
//   aClock                 in   system clock, rising edge
//   aReset                 in   synchronous active-high reset
//   aFrameDone             in   renderer finished back buffer (level, held
//                               until anOutFrameFlipped)
//   aScanStart             in   1-cycle pulse at scan-out pixel (0,0)
//   anOutFrameFlipped      out  1-cycle pulse: fresh back buffer ready
//   anOutFrontBase         out  scan-out read base address
//   anOutBackBase          out  renderer write base address
//   anOutRenderWriteEnable out  renderer may write the back buffer
//   anOutClearWriteEnable  out  clear engine write strobe
//   anOutClearAddress      out  clear engine write address
//   anOutClearData         out  clear engine write data
//   anOutBusy              out  high whenever not in RENDER
//   anOutFrameCount        out  number of completed flips, wraps at 16 bits
// ---------------------------------------------------------------------------
module framebuffer_swap_controller #(
  parameter int unsigned FB_SIZE = 76800,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned DATA_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  aClock,
  input  logic                  aReset,
  input  logic                  aFrameDone,
  input  logic                  aScanStart,
  output logic                  anOutFrameFlipped,
  output logic [ADDR_WIDTH-1:0] anOutFrontBase,
  output logic [ADDR_WIDTH-1:0] anOutBackBase,
  output logic                  anOutRenderWriteEnable,
  output logic                  anOutClearWriteEnable,
  output logic [ADDR_WIDTH-1:0] anOutClearAddress,
  output logic [DATA_WIDTH-1:0] anOutClearData,
  output logic                  anOutBusy,
  output logic [15:0]           anOutFrameCount
);

  localparam logic [ADDR_WIDTH-1:0] BUFFER_BASE = ADDR_WIDTH'(FB_SIZE);

  typedef enum logic [2:0] {
    RENDER    = 3'd0,
    WAIT_SCAN = 3'd1,
    FLIP      = 3'd2,
    RELEASE   = 3'd3
`ifdef CLEAR_ON_FLIP_EN
    ,
    CLEAR     = 3'd4
`endif
  } swapStateT;

  swapStateT             stateReg;
  swapStateT             stateNext;
  logic                  selectReg;
  logic [15:0]           frameCountReg;
  logic [ADDR_WIDTH-1:0] frontBaseReg;
  logic [ADDR_WIDTH-1:0] backBaseReg;
  logic                  flippedReg;

`ifdef CLEAR_ON_FLIP_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = BUFFER_BASE - ADDR_WIDTH'(1);
  logic [ADDR_WIDTH-1:0] clearCountReg;
`endif

  // Next-state logic. The request from the renderer is latched by leaving
  // RENDER, so a later drop of aFrameDone cannot cancel a pending flip, and a
  // scan start coinciding with the request is not seen until WAIT_SCAN.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      RENDER:    if (aFrameDone) stateNext = WAIT_SCAN;
      WAIT_SCAN: if (aScanStart) stateNext = FLIP;
`ifdef CLEAR_ON_FLIP_EN
      FLIP:      stateNext = CLEAR;
      CLEAR:     if (clearCountReg == LAST_INDEX) stateNext = RELEASE;
`else
      FLIP:      stateNext = RELEASE;
`endif
      RELEASE:   stateNext = RENDER;
      default:   stateNext = RENDER;
    endcase
  end

  always_ff @(posedge aClock) begin
    if (aReset) begin
      stateReg      <= RENDER;
      selectReg     <= 1'b0;
      frameCountReg <= 16'd0;
      frontBaseReg  <= '0;
      backBaseReg   <= BUFFER_BASE;
      flippedReg    <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      flippedReg <= (stateNext == RELEASE);
      if (stateReg == FLIP) begin
        selectReg     <= ~selectReg;
        frameCountReg <= frameCountReg + 16'd1;
        // Bases follow the new select value so they change together with it.
        frontBaseReg  <= selectReg ? '0 : BUFFER_BASE;
        backBaseReg   <= selectReg ? BUFFER_BASE : '0;
      end
    end
  end

`ifdef CLEAR_ON_FLIP_EN
  always_ff @(posedge aClock) begin
    if (aReset) begin
      clearCountReg <= '0;
    end else if (stateReg == CLEAR) begin
      clearCountReg <= (clearCountReg == LAST_INDEX) ? '0 : clearCountReg + ADDR_WIDTH'(1);
    end
  end

  // Back base already points at the new back buffer while in CLEAR.
  assign anOutClearWriteEnable = (stateReg == CLEAR);
  assign anOutClearAddress     = backBaseReg + clearCountReg;
  assign anOutClearData        = CLEAR_VALUE;
`else
  assign anOutClearWriteEnable = 1'b0;
  assign anOutClearAddress     = '0;
  assign anOutClearData        = '0;
`endif

  assign anOutFrameFlipped      = flippedReg;
  assign anOutFrontBase         = frontBaseReg;
  assign anOutBackBase          = backBaseReg;
  assign anOutRenderWriteEnable = (stateReg == RENDER) && !aFrameDone;
  assign anOutBusy              = (stateReg != RENDER);
  assign anOutFrameCount        = frameCountReg;

endmodule

// File: tb/tb_framebuffer_swap_controller.sv
module tb_framebuffer_swap_controller;

`ifdef CLEAR_ON_FLIP_EN
  localparam int FB = 16;
  localparam int CLEAR_CYCLES = 16;
`else
  localparam int FB = 76800;
  localparam int CLEAR_CYCLES = 0;
`endif
  localparam int AW = 18;
  localparam int DW = 3;
  localparam logic [DW-1:0] CV = 3'd5;

  logic          aClock;
  logic          aReset;
  logic          aFrameDone;
  logic          aScanStart;
  logic          anOutFrameFlipped;
  logic [AW-1:0] anOutFrontBase;
  logic [AW-1:0] anOutBackBase;
  logic          anOutRenderWriteEnable;
  logic          anOutClearWriteEnable;
  logic [AW-1:0] anOutClearAddress;
  logic [DW-1:0] anOutClearData;
  logic          anOutBusy;
  logic [15:0]   anOutFrameCount;

  int          vectorCount = 0;
  int          missCount = 0;
  logic        benchSelect = 1'b0;
  logic [15:0] benchCount = 16'd0;

  framebuffer_swap_controller #(
    .FB_SIZE(FB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_VALUE(CV)
  ) dut (
    .aClock(aClock),
    .aReset(aReset),
    .aFrameDone(aFrameDone),
    .aScanStart(aScanStart),
    .anOutFrameFlipped(anOutFrameFlipped),
    .anOutFrontBase(anOutFrontBase),
    .anOutBackBase(anOutBackBase),
    .anOutRenderWriteEnable(anOutRenderWriteEnable),
    .anOutClearWriteEnable(anOutClearWriteEnable),
    .anOutClearAddress(anOutClearAddress),
    .anOutClearData(anOutClearData),
    .anOutBusy(anOutBusy),
    .anOutFrameCount(anOutFrameCount)
  );

  initial aClock = 1'b0;
  always #5 aClock = ~aClock;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge aClock);
  endtask

  function automatic logic [31:0] frontFor(input logic sel);
    return sel ? 32'(FB) : 32'd0;
  endfunction

  function automatic logic [31:0] backFor(input logic sel);
    return sel ? 32'd0 : 32'(FB);
  endfunction

  // Completes one flip. If alreadyWaiting is clear, the request is raised
  // first; otherwise the controller is expected to sit in WAIT_SCAN already.
  task automatic runFlip(input bit alreadyWaiting);
    int lat;
    int writes;
    if (!alreadyWaiting) begin
      aFrameDone = 1'b1;
      #1;
      checkVal("render_en_drop", 32'(anOutRenderWriteEnable), 32'd0);
      tick();
    end
    checkVal("busy_waiting", 32'(anOutBusy), 32'd1);
    repeat (3) tick();
    checkVal("no_early_flip", 32'(anOutFrameFlipped), 32'd0);
    aScanStart = 1'b1;
    tick();
    aScanStart = 1'b0;
    // Now in FLIP: no pulse yet, bases still the old ones.
    checkVal("flip_no_pulse", 32'(anOutFrameFlipped), 32'd0);
    checkVal("flip_front_old", 32'(anOutFrontBase), frontFor(benchSelect));
    lat = 0;
    writes = 0;
    while (!anOutFrameFlipped && lat < CLEAR_CYCLES + 10) begin
      tick();
      lat++;
      if (anOutClearWriteEnable) begin
        checkVal("clear_addr", 32'(anOutClearAddress), backFor(~benchSelect) + 32'(writes));
        checkVal("clear_data", 32'(anOutClearData), 32'(CV));
        checkVal("clear_no_render", 32'(anOutRenderWriteEnable), 32'd0);
        writes++;
      end
    end
    checkVal("flip_latency", 32'(lat), 32'(CLEAR_CYCLES + 1));
    checkVal("clear_writes", 32'(writes), 32'(CLEAR_CYCLES));
    benchSelect = ~benchSelect;
    benchCount = benchCount + 16'd1;
    checkVal("frame_count", 32'(anOutFrameCount), 32'(benchCount));
    aFrameDone = 1'b0;
    tick();
    checkVal("single_pulse", 32'(anOutFrameFlipped), 32'd0);
    checkVal("busy_idle", 32'(anOutBusy), 32'd0);
    checkVal("front_base", 32'(anOutFrontBase), frontFor(benchSelect));
    checkVal("back_base", 32'(anOutBackBase), backFor(benchSelect));
    $display("flip done: count=%0d front=0x%0h back=0x%0h latency=%0d", anOutFrameCount,
             anOutFrontBase, anOutBackBase, lat);
  endtask

  task automatic checkResetState(input string tag);
    checkVal({tag, "_front"}, 32'(anOutFrontBase), 32'd0);
    checkVal({tag, "_back"}, 32'(anOutBackBase), 32'(FB));
    checkVal({tag, "_count"}, 32'(anOutFrameCount), 32'd0);
    checkVal({tag, "_busy"}, 32'(anOutBusy), 32'd0);
    checkVal({tag, "_render_en"}, 32'(anOutRenderWriteEnable), 32'd1);
    checkVal({tag, "_flipped"}, 32'(anOutFrameFlipped), 32'd0);
    checkVal({tag, "_clear_we"}, 32'(anOutClearWriteEnable), 32'd0);
    $display("reset check %s: front=0x%0h back=0x%0h count=%0d", tag, anOutFrontBase,
             anOutBackBase, anOutFrameCount);
  endtask

  initial begin
    int strayEvents;
    aReset = 1'b1;
    aFrameDone = 1'b0;
    aScanStart = 1'b0;
    tick();
    tick();
    aReset = 1'b0;
    checkResetState("reset");

    // Scan start while rendering is ignored.
    aScanStart = 1'b1;
    tick();
    aScanStart = 1'b0;
    checkVal("scan_ignored_busy", 32'(anOutBusy), 32'd0);
    $display("scan start in RENDER: busy=%0d", anOutBusy);

    // Basic flip, then a second one back to the original orientation.
    runFlip(1'b0);
    runFlip(1'b0);

    // Request and scan start in the same cycle: that scan start is not used.
    // The request is then dropped while waiting; the flip must still happen.
    aFrameDone = 1'b1;
    aScanStart = 1'b1;
    tick();
    aScanStart = 1'b0;
    repeat (3) tick();
    checkVal("simul_no_flip", 32'(anOutFrameFlipped), 32'd0);
    checkVal("simul_count_held", 32'(anOutFrameCount), 32'(benchCount));
    checkVal("simul_front_held", 32'(anOutFrontBase), frontFor(benchSelect));
    $display("simultaneous request/scan: busy=%0d count=%0d", anOutBusy, anOutFrameCount);
    aFrameDone = 1'b0;
    tick();
    runFlip(1'b1);

    // Reset in the middle of a pending flip (mid-clear when clearing is built).
    aFrameDone = 1'b1;
    tick();
`ifdef CLEAR_ON_FLIP_EN
    aScanStart = 1'b1;
    tick();
    aScanStart = 1'b0;
    repeat (8) tick();
    checkVal("mid_clear_addr", 32'(anOutClearAddress), backFor(~benchSelect) + 32'd7);
`else
    tick();
`endif
    checkVal("mid_busy", 32'(anOutBusy), 32'd1);
    aReset = 1'b1;
    aFrameDone = 1'b0;
    tick();
    aReset = 1'b0;
    benchSelect = 1'b0;
    benchCount = 16'd0;
    checkResetState("mid_reset");
    strayEvents = 0;
    repeat (24) begin
      tick();
      if (anOutFrameFlipped || anOutClearWriteEnable || anOutBusy) strayEvents++;
    end
    checkVal("post_reset_quiet", 32'(strayEvents), 32'd0);

    // Frame counter wrap, with the counter preloaded to its maximum.
    force dut.frameCountReg = 16'hFFFF;
    tick();
    release dut.frameCountReg;
    tick();
    checkVal("preload_count", 32'(anOutFrameCount), 32'hFFFF);
    benchCount = 16'hFFFF;
    runFlip(1'b0);
    checkVal("wrap_count_zero", 32'(anOutFrameCount), 32'd0);
    runFlip(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
